// File: rtl/apb_periph_pkg.sv
// Shared APB peripheral definitions: register map, STATUS layout, FSM encoding.
package apb_periph_pkg;

    localparam int unsigned APB_AW       = 16;
    localparam int unsigned APB_DW       = 32;
    localparam int unsigned THRESH_W     = 5;
    localparam int unsigned STAT_COUNT_W = 5;
    localparam int unsigned WAIT_W       = 2;

    // Register index lives in PADDR[3:2]; anything above bit 3 must be zero.
    localparam int unsigned REG_IDX_LSB  = 2;
    localparam int unsigned REG_IDX_MSB  = 3;
    localparam int unsigned ADDR_HI_LSB  = 4;

    localparam int unsigned STAT_OVF_BIT    = 8;
    localparam int unsigned STAT_UNF_BIT    = 9;
    localparam int unsigned CTRL_IRQ_EN_BIT = 0;
    localparam int unsigned CTRL_FLUSH_BIT  = 1;

    localparam logic [THRESH_W-1:0] THRESH_RST = 5'd1;

    // Register offsets 0x0/0x4/0x8/0xC expressed as PADDR[3:2] indices.
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } reg_sel_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    typedef struct packed {
        logic [21:0]             rsvd_hi;
        logic                    unf;
        logic                    ovf;
        logic                    rsvd_lo;
        logic [STAT_COUNT_W-1:0] count;
        logic                    full;
        logic                    empty;
    } status_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: unreset storage, wrapping pointers and an occupancy count.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [DW-1:0]          i_wdata,
    output logic [DW-1:0]          o_rdata_c,
    output logic                   o_full_c,
    output logic                   o_empty_c,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_rdata_c = r_mem[r_rptr];
    assign o_count   = r_count;

    // Push to a full FIFO or pop from an empty one leaves state untouched.
    assign w_do_push = i_push && !o_full_c;
    assign w_do_pop  = i_pop && !o_empty_c;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB slave exposing a FIFO with status, control, threshold and level interrupt.
module apb_fifo_slave
    import apb_periph_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iPSEL,
    input  logic              iPENABLE,
    input  logic              iPWRITE,
    input  logic [APB_AW-1:0] iPADDR,
    input  logic [APB_DW-1:0] iPWDATA,
    output logic [APB_DW-1:0] oPRDATA,
    output logic              oPREADY,
    output logic              oIrq
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    apb_state_e          r_state;
    apb_state_e          w_state_nxt;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                w_ready;

    logic                r_irq_en;
    logic [THRESH_W-1:0] r_thresh;
    logic                r_ovf;
    logic                r_unf;
    logic                r_irq;

    logic                w_addr_ok;
    reg_sel_e            w_sel;
    logic                w_wr_en;
    logic                w_rd_en;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic [APB_DW-1:0]   w_head;
    logic [APB_DW-1:0]   w_rmux;
    status_t             w_status;
    logic                w_unused;

    // FSM state and wait-state counter.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Next state, wait counting and ready; reset kills a completing transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iPSEL && !iPENABLE) begin
                    w_state_nxt = ST_ACCESS;
                    w_wait_nxt  = '0;
                end
            end
            ST_ACCESS: begin
                w_ready = !iRst && iPSEL && iPENABLE && (r_wait == WAIT_W'(WAIT_CYCLES));
                if (r_wait != WAIT_W'(WAIT_CYCLES)) begin
                    w_wait_nxt = r_wait + WAIT_W'(1);
                end
                if (w_ready || !iPSEL) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign oPREADY   = w_ready;
    assign w_addr_ok = (iPADDR[APB_AW-1:ADDR_HI_LSB] == '0);
    assign w_sel     = reg_sel_e'(iPADDR[REG_IDX_MSB:REG_IDX_LSB]);
    assign w_wr_en   = w_ready && iPWRITE && w_addr_ok;
    assign w_rd_en   = w_ready && !iPWRITE && w_addr_ok;
    assign w_push    = w_wr_en && (w_sel == REG_DATA);
    assign w_pop     = w_rd_en && (w_sel == REG_DATA);
    assign w_flush   = w_wr_en && (w_sel == REG_CTRL) && iPWDATA[CTRL_FLUSH_BIT];
    assign w_unused  = ^iPADDR[REG_IDX_LSB-1:0];

    sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (APB_DW)
    ) u_fifo (
        .i_clk     (iClk),
        .i_rst     (iRst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .i_wdata   (iPWDATA),
        .o_rdata_c (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_count   (w_count)
    );

    always_comb begin
        w_status       = '0;
        w_status.empty = w_empty;
        w_status.full  = w_full;
        w_status.count = STAT_COUNT_W'(w_count);
        w_status.ovf   = r_ovf;
        w_status.unf   = r_unf;
    end

    // Read mux; out-of-range addresses read as zero.
    always_comb begin
        w_rmux = '0;
        if (w_addr_ok) begin
            case (w_sel)
                REG_DATA:   w_rmux = w_empty ? '0 : w_head;
                REG_STATUS: w_rmux = w_status;
                REG_CTRL:   w_rmux[CTRL_IRQ_EN_BIT] = r_irq_en;
                REG_THRESH: w_rmux = APB_DW'(r_thresh);
                default:    w_rmux = '0;
            endcase
        end
    end

    assign oPRDATA = (w_ready && !iPWRITE) ? w_rmux : '0;

    // Sticky flags, control registers and the registered level interrupt.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_irq_en <= 1'b0;
            r_thresh <= THRESH_RST;
            r_irq    <= 1'b0;
        end else begin
            r_irq <= r_irq_en && (THRESH_W'(w_count) >= r_thresh);
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_pop && w_empty) begin
                r_unf <= 1'b1;
            end
            if (w_wr_en) begin
                case (w_sel)
                    REG_STATUS: begin
                        if (iPWDATA[STAT_OVF_BIT]) begin
                            r_ovf <= 1'b0;
                        end
                        if (iPWDATA[STAT_UNF_BIT]) begin
                            r_unf <= 1'b0;
                        end
                    end
                    // A flush write is a pure command and keeps the enable as is.
                    REG_CTRL: begin
                        if (!iPWDATA[CTRL_FLUSH_BIT]) begin
                            r_irq_en <= iPWDATA[CTRL_IRQ_EN_BIT];
                        end
                    end
                    REG_THRESH: r_thresh <= iPWDATA[THRESH_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign oIrq = r_irq;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Directed bench for apb_fifo_slave (DEPTH=8, WAIT_CYCLES=1).
module tb_apb_fifo_slave;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iPSEL;
    logic        iPENABLE;
    logic        iPWRITE;
    logic [15:0] iPADDR;
    logic [31:0] iPWDATA;
    logic [31:0] oPRDATA;
    logic        oPREADY;
    logic        oIrq;

    int n_total = 0;
    int n_pass  = 0;

    apb_fifo_slave #(.DEPTH(8), .WAIT_CYCLES(1)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iPSEL    (iPSEL),
        .iPENABLE (iPENABLE),
        .iPWRITE  (iPWRITE),
        .iPADDR   (iPADDR),
        .iPWDATA  (iPWDATA),
        .oPRDATA  (oPRDATA),
        .oPREADY  (oPREADY),
        .oIrq     (oIrq)
    );

    always #5 iClk = ~iClk;

    // One APB transfer starting now (just after a rising edge); ends 1ns after the completing edge.
    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int acc);
        bit done;
        done = 0;
        acc  = 0;
        rd   = '0;
        iPSEL = 1'b1; iPENABLE = 1'b0; iPWRITE = wr; iPADDR = addr; iPWDATA = wd;
        @(posedge iClk); #1;
        iPENABLE = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge iClk);
            acc++;
            if (oPREADY === 1'b1) begin
                rd   = oPRDATA;
                done = 1;
            end
            @(posedge iClk); #1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL xfer_timeout addr=%h: no PREADY within 8 cycles", addr);
        end
    endtask

    task automatic idle();
        iPSEL = 1'b0; iPENABLE = 1'b0; iPWRITE = 1'b0;
        @(posedge iClk); #1;
    endtask

    task automatic apb_wr(input logic [15:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        int a;
        xfer(1'b1, addr, wd, d, a);
        idle();
    endtask

    task automatic apb_rd(input logic [15:0] addr, output logic [31:0] rd);
        int a;
        xfer(1'b0, addr, 32'h0, rd, a);
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        n_total++;
        if (oPREADY !== 1'b0) $display("FAIL reset_pready: got %b expected 0", oPREADY); else n_pass++;
        n_total++;
        if (oPRDATA !== 32'h0) $display("FAIL reset_prdata: got %h expected 00000000", oPRDATA); else n_pass++;
        n_total++;
        if (oIrq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", oIrq); else n_pass++;
        iRst = 1'b0;
        @(posedge iClk); #1;
        apb_rd(16'h0004, d);
        n_total++;
        if (d !== 32'h001) $display("FAIL reset_status: got %h expected 00000001", d); else n_pass++;
        apb_rd(16'h0008, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL reset_ctrl: got %h expected 00000000", d); else n_pass++;
        apb_rd(16'h000C, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL reset_thresh: got %h expected 00000001", d); else n_pass++;
    endtask

    task automatic test_push_pop();
        logic [31:0] d;
        int a;
        xfer(1'b1, 16'h0000, 32'hDEADBEEF, d, a);
        idle();
        n_total++;
        if (a !== 2) $display("FAIL push_latency: got %0d expected 2", a); else n_pass++;
        xfer(1'b0, 16'h0000, 32'h0, d, a);
        idle();
        n_total++;
        if (a !== 2) $display("FAIL pop_latency: got %0d expected 2", a); else n_pass++;
        n_total++;
        if (d !== 32'hDEADBEEF) $display("FAIL pop_data: got %h expected deadbeef", d); else n_pass++;
        apb_rd(16'h0004, d);
        n_total++;
        if (d !== 32'h001) $display("FAIL pushpop_status: got %h expected 00000001", d); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 1; i <= 9; i++) apb_wr(16'h0000, 32'(i));
        apb_rd(16'h0004, d);
        n_total++;
        if (d !== 32'h122) $display("FAIL ovf_status: got %h expected 00000122", d); else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            apb_rd(16'h0000, d);
            n_total++;
            if (d !== 32'(i)) $display("FAIL ovf_pop%0d: got %h expected %h", i, d, 32'(i)); else n_pass++;
        end
        apb_rd(16'h0000, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL unf_pop: got %h expected 00000000", d); else n_pass++;
        apb_rd(16'h0004, d);
        n_total++;
        if (d !== 32'h301) $display("FAIL unf_status: got %h expected 00000301", d); else n_pass++;
    endtask

    task automatic test_wrap_w1c();
        logic [31:0] d;
        logic [31:0] exp;
        int errs;
        errs = 0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) apb_wr(16'h0000, 32'h1000 + 32'(r * 5 + i));
            for (int i = 0; i < 5; i++) begin
                exp = 32'h1000 + 32'(r * 5 + i);
                apb_rd(16'h0000, d);
                n_total++;
                if (d !== exp) $display("FAIL wrap_pop%0d: got %h expected %h", r * 5 + i, d, exp); else n_pass++;
            end
        end
        apb_wr(16'h0004, 32'h300);
        apb_rd(16'h0004, d);
        n_total++;
        if (d !== 32'h001) $display("FAIL w1c_status: got %h expected 00000001", d); else n_pass++;
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int a;
        apb_wr(16'h000C, 32'h3);
        apb_wr(16'h0008, 32'h1);
        apb_wr(16'h0000, 32'hA1);
        apb_wr(16'h0000, 32'hA2);
        xfer(1'b1, 16'h0000, 32'hA3, d, a);
        n_total++;
        if (oIrq !== 1'b0) $display("FAIL irq_early: got %b expected 0", oIrq); else n_pass++;
        idle();
        n_total++;
        if (oIrq !== 1'b1) $display("FAIL irq_rise: got %b expected 1", oIrq); else n_pass++;
        apb_rd(16'h0000, d);
        n_total++;
        if (d !== 32'hA1) $display("FAIL irq_pop: got %h expected 000000a1", d); else n_pass++;
        n_total++;
        if (oIrq !== 1'b0) $display("FAIL irq_fall: got %b expected 0", oIrq); else n_pass++;
        apb_wr(16'h0008, 32'h2);
        apb_rd(16'h0004, d);
        n_total++;
        if (d !== 32'h001) $display("FAIL flush_status: got %h expected 00000001", d); else n_pass++;
        apb_rd(16'h0008, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL flush_ctrl: got %h expected 00000001", d); else n_pass++;
        apb_wr(16'h000C, 32'h0);
        n_total++;
        if (oIrq !== 1'b1) $display("FAIL irq_thresh0: got %b expected 1", oIrq); else n_pass++;
        apb_wr(16'h0008, 32'h0);
        n_total++;
        if (oIrq !== 1'b0) $display("FAIL irq_disable: got %b expected 0", oIrq); else n_pass++;
        apb_wr(16'h000C, 32'h1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int a;
        xfer(1'b1, 16'h0000, 32'hB0B0_0001, d, a);
        xfer(1'b1, 16'h0000, 32'hB0B0_0002, d, a);
        n_total++;
        if (a !== 2) $display("FAIL b2b_latency: got %0d expected 2", a); else n_pass++;
        xfer(1'b0, 16'h0000, 32'h0, d, a);
        n_total++;
        if (d !== 32'hB0B0_0001) $display("FAIL b2b_pop1: got %h expected b0b00001", d); else n_pass++;
        xfer(1'b0, 16'h0000, 32'h0, d, a);
        n_total++;
        if (d !== 32'hB0B0_0002) $display("FAIL b2b_pop2: got %h expected b0b00002", d); else n_pass++;
        idle();
        apb_rd(16'h0004, d);
        n_total++;
        if (d !== 32'h001) $display("FAIL b2b_status: got %h expected 00000001", d); else n_pass++;
    endtask

    task automatic test_bad_addr();
        logic [31:0] d;
        int a;
        xfer(1'b1, 16'h0010, 32'h1234, d, a);
        idle();
        n_total++;
        if (a !== 2) $display("FAIL bad_wr_ready: got %0d expected 2", a); else n_pass++;
        apb_wr(16'h100C, 32'h1F);
        apb_rd(16'h000C, d);
        n_total++;
        if (d !== 32'h1) $display("FAIL bad_thresh: got %h expected 00000001", d); else n_pass++;
        apb_rd(16'h8004, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL bad_rd: got %h expected 00000000", d); else n_pass++;
        apb_rd(16'h0004, d);
        n_total++;
        if (d !== 32'h001) $display("FAIL bad_status: got %h expected 00000001", d); else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] d;
        iPSEL = 1'b1; iPENABLE = 1'b0; iPWRITE = 1'b1; iPADDR = 16'h0000; iPWDATA = 32'h55;
        @(posedge iClk); #1;
        iPENABLE = 1'b1;
        @(negedge iClk);
        n_total++;
        if (oPREADY !== 1'b0) $display("FAIL abort_wait: got %b expected 0", oPREADY); else n_pass++;
        @(posedge iClk); #1;
        iPSEL = 1'b0; iPENABLE = 1'b0;
        @(posedge iClk); #1;
        apb_rd(16'h0004, d);
        n_total++;
        if (d !== 32'h001) $display("FAIL abort_status: got %h expected 00000001", d); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        apb_wr(16'h0008, 32'h1);
        for (int i = 0; i < 5; i++) apb_wr(16'h0000, 32'hC0 + 32'(i));
        apb_rd(16'h0004, d);
        n_total++;
        if (d !== 32'h014) $display("FAIL pre_rst_status: got %h expected 00000014", d); else n_pass++;
        n_total++;
        if (oIrq !== 1'b1) $display("FAIL pre_rst_irq: got %b expected 1", oIrq); else n_pass++;
        iPSEL = 1'b1; iPENABLE = 1'b0; iPWRITE = 1'b1; iPADDR = 16'h0000; iPWDATA = 32'h77;
        @(posedge iClk); #1;
        iPENABLE = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b1;
        @(negedge iClk);
        n_total++;
        if (oPREADY !== 1'b0) $display("FAIL rst_pready: got %b expected 0", oPREADY); else n_pass++;
        @(posedge iClk); #1;
        iRst = 1'b0; iPSEL = 1'b0; iPENABLE = 1'b0;
        n_total++;
        if (oIrq !== 1'b0) $display("FAIL rst_irq: got %b expected 0", oIrq); else n_pass++;
        apb_rd(16'h0004, d);
        n_total++;
        if (d !== 32'h001) $display("FAIL rst_status: got %h expected 00000001", d); else n_pass++;
        apb_rd(16'h0008, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL rst_ctrl: got %h expected 00000000", d); else n_pass++;
    endtask

    initial begin
        iRst = 1'b1; iPSEL = 1'b0; iPENABLE = 1'b0; iPWRITE = 1'b0;
        iPADDR = '0; iPWDATA = '0;
        repeat (3) @(posedge iClk);
        #1;
        test_reset();
        test_push_pop();
        test_overflow();
        test_wrap_w1c();
        test_irq();
        test_back_to_back();
        test_bad_addr();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb_fifo_slave.md
APB_FIFO_SLAVE -- requirements
Module: apb_fifo_slave

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the FIFO entries as a power of two from 2 to 16.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, giving the APB access-phase wait states, range 0 to 3.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: iClk input 1 is the rising-edge clock, and iRst input 1 is the synchronous active-high reset.
REQ-004 The block SHALL have iPSEL, input, 1 bit: this slave's select bit, driven by one bit of the bridge's oPSEL.
REQ-005 The block SHALL have iPENABLE, input, 1 bit: APB enable.
REQ-006 The block SHALL have iPWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-007 The block SHALL have iPADDR, input, 16 bits: byte address.
REQ-008 The block SHALL have iPWDATA, input, 32 bits: write data.
REQ-009 The block SHALL have oPRDATA, output, 32 bits: read data, valid only while oPREADY=1.
REQ-010 The block SHALL have oPREADY, output, 1 bit: transfer completes in this cycle.
REQ-011 The block SHALL have oIrq, output, 1 bit: level interrupt, high when the FIFO level has reached the threshold.

Function
REQ-012 The register map SHALL decode on iPADDR[3:2] as follows:
  - 0x0 DATA: write pushes; read pops.
  - 0x4 STATUS, read-only except W1C: [0] empty, [1] full, [6:2] count, [8] overflow (sticky), [9] underflow (sticky).
  - 0x8 CTRL: [0] irq enable (RW); [1] flush (write-1, self-clearing, reads 0).
  - 0xC THRESH: [4:0] RW, reset value 1.
REQ-013 If iPADDR[15:4] is nonzero, a read SHALL return 0, a write SHALL be ignored, and oPREADY SHALL still be generated.
REQ-014 The FSM SHALL have two states, IDLE and ACCESS.
  - IDLE goes to ACCESS when iPSEL=1 and iPENABLE=0.
  - ACCESS goes to IDLE when oPREADY=1, or when iPSEL=0 (aborted transfer, no side effect).
REQ-015 The wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle, saturating at WAIT_CYCLES.
REQ-016 oPREADY SHALL equal (state==ACCESS and count==WAIT_CYCLES and iPSEL and iPENABLE).
  - With WAIT_CYCLES=0, oPREADY rises in the first access cycle.
REQ-017 Register side effects (push, pop, flush, W1C, CTRL/THRESH update) SHALL occur only on the clock edge ending the oPREADY=1 cycle, exactly once per transfer.
REQ-018 oPRDATA SHALL be 0 whenever oPREADY=0; when oPREADY=1 and the transfer is a read, it SHALL be the combinational read mux.
  - A DATA read returns the FIFO head.
REQ-019 The FIFO SHALL use read and write pointers of log2(DEPTH) bits with natural wrap, and a count of log2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0).
REQ-020 A push while full SHALL drop the data, leave pointers and count unchanged, and set overflow.
REQ-021 A pop while empty SHALL return 0, leave pointers unchanged, and set underflow.
REQ-022 A flush SHALL zero the pointers and count but leave the sticky flags and memory contents unchanged.
REQ-023 A STATUS write with bit 8 or 9 set SHALL clear the corresponding sticky flag; other STATUS bits SHALL ignore writes.
REQ-024 oIrq SHALL be registered and equal irq_en and (count >= THRESH), updated one cycle after count or THRESH changes.
  - THRESH=0 with irq_en=1 asserts oIrq permanently.
REQ-025 Back-to-back transfers SHALL be supported: a setup cycle immediately following the completing access cycle is accepted from IDLE.

Reset
REQ-026 Reset SHALL be synchronous and active-high on iRst.
REQ-027 While iRst=1 at a rising edge, the following SHALL be set on the next cycle:
  - FSM = IDLE, wait counter = 0.
  - Pointers and count = 0.
  - overflow = underflow = 0, irq_en = 0, THRESH = 1.
  - oPREADY = 0, oPRDATA = 0, oIrq = 0.
REQ-028 The FIFO memory SHALL NOT be reset.
REQ-029 A reset asserted mid-transfer SHALL abort the transfer with no side effect; the master re-issues it.

Structure
REQ-030 Register offsets, STATUS bit positions, and FSM state encodings SHALL live in shared package apb_periph_pkg.
REQ-031 The FIFO storage, pointers, and count SHALL be one sub-module, sync_fifo (ports: push, pop, flush, wdata, rdata, full, empty, count).
  - The APB FSM and register decode remain in apb_fifo_slave.

Verification
REQ-032 Push then pop: with WAIT_CYCLES=1, write 0x0=0xDEADBEEF, then read 0x0 -> oPREADY high in the 2nd access cycle, oPRDATA=0xDEADBEEF, and STATUS then reads 0x1.
REQ-033 Overflow: push 9 words 0x1..0x9 with DEPTH=8 -> STATUS=0x122. Then pop 8 times -> returns 0x1..0x8 in order. The 9th pop returns 0 and STATUS=0x301.
REQ-034 Wrap and W1C: with the pointers wrapped, push and pop 20 words -> the data order is preserved. Then write STATUS=0x300 -> STATUS=0x001.
REQ-035 IRQ: set THRESH=3 and CTRL=0x1, then push 3 words -> oIrq rises one cycle after the 3rd push completes. One pop -> oIrq falls. CTRL=0x2 flush -> count=0 and irq_en stays 1.
REQ-036 Abort and reset: PSEL dropped during the wait state -> no push, FSM back to IDLE. iRst pulsed mid-access with count=5 -> oPREADY=0, STATUS=0x001, oIrq=0.
